load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter SIZE_WARD, default 2, giving memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default $clog2(4*SIZE_WARD), giving the byte-address width.
REQ-003 SHALL have parameter RD_LAT, default 1, giving memory read latency in cycles (range 1..7).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: CPU request present.
REQ-007 SHALL have port req_ready, output, 1 bit: unit accepts a request.
REQ-008 SHALL have port req_op, input, 3 bits: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW.
REQ-009 SHALL have port req_addr, input, AW bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: response present.
REQ-012 SHALL have port resp_ready, input, 1 bit: CPU takes the response.
REQ-013 SHALL have port resp_data, output, 32 bits: load result; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit: misaligned access.
REQ-015 SHALL have port address, output, AW bits: word-aligned memory address.
REQ-016 SHALL have port write_data, output, 32 bits: memory write word.
REQ-017 SHALL have port memread, output, 1 bit: memory read strobe.
REQ-018 SHALL have port memwrite, output, 1 bit: memory write strobe.
REQ-019 SHALL have port read_data, input, 32 bits: memory read word.

Function
REQ-020 SHALL treat memory as big-endian: byte offset k = addr[1:0] occupies bits [31-8k : 24-8k]; halfword at k=0 is [31:16], at k=2 is [15:0].
REQ-021 SHALL drive address = {req_addr[AW-1:2], 2'b00}, held stable for the whole transaction.
REQ-022 SHALL implement FSM states IDLE, RD_WAIT, WR, RESP; req_ready=1 only in IDLE.
REQ-023 SHALL capture op/addr/wdata on req_valid && req_ready.
REQ-024 SHALL flag as misaligned any halfword with addr[0]=1 and any word with addr[1:0]!=0; IDLE->RESP, resp_err=1, no memread/memwrite.
REQ-025 SHALL sequence loads as IDLE->RD_WAIT, with memread high for exactly RD_LAT cycles, sample read_data on the last cycle, then ->RESP.
REQ-026 SHALL sign-extend LB/LH results and zero-extend LBU/LHU results; LW returns the word unchanged.
REQ-027 SHALL sequence SW as IDLE->WR, with memwrite high for 1 cycle and write_data=wdata, then ->RESP.
REQ-028 SHALL perform SB/SH as read-modify-write: RD_WAIT reads the word; WR writes it with only the addressed byte/halfword lane replaced by wdata[7:0]/[15:0]; ->RESP.
REQ-029 SHALL never assert memread and memwrite in the same cycle.
REQ-030 SHALL hold resp_valid, resp_data and resp_err stable in RESP until resp_ready=1, then return to IDLE.
REQ-031 SHALL, when resp_ready=1 on the first RESP cycle, spend exactly 1 cycle in RESP; back-to-back throughput is one request per (RESP exit + 1) cycles.
REQ-032 SHALL ignore req_valid outside IDLE.

Reset
REQ-033 SHALL, on rst_n=0 at any time including mid-transaction, force state IDLE, memread=0, memwrite=0, resp_valid=0, resp_err=0, resp_data=0, write_data=0, address=0, req_ready=0.
REQ-034 SHALL assert req_ready on the first rising clk edge after rst_n deasserts; an aborted RMW leaves memory unmodified.

Structure
REQ-035 SHALL place the op encodings, FSM state encodings and RD_LAT bound in a shared package, mips_mem_pkg.
REQ-036 SHALL contain one sub-module, lane_merge, which is combinational and performs byte/halfword insert and extract with sign/zero extension.

Verification
REQ-037 Memory word 0 = 0x801234FF; LB addr 0 -> resp_data 0xFFFFFF80, err 0, one memread burst of RD_LAT cycles.
REQ-038 Same memory contents; LBU addr 3 -> 0x000000FF; LH addr 2 -> 0x000034FF; LHU addr 0 -> 0x00008012.
REQ-039 SB addr 1, wdata 0x000000AB -> memread burst then one memwrite with write_data 0x80AB34FF; no overlap of memread and memwrite.
REQ-040 LW addr 2 and SH addr 3 -> resp_err 1, resp_data 0, memread and memwrite never asserted.
REQ-041 LW with resp_ready held low 3 cycles -> resp_valid and resp_data constant for 4 cycles; req_ready low throughout.
REQ-042 rst_n pulsed low during WR of SH -> memwrite drops asynchronously, memory word unchanged, req_ready=1 at the next edge.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// ============================================================================
// mips_mem_pkg : op and FSM encodings shared by the load/store unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR      = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_e;

    localparam int RD_LAT_MAX = 7;
    localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX + 1);

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return (off != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_merge.sv
// ============================================================================
// lane_merge : big-endian byte/halfword extract (with extension) and insert
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_merge
    import mips_mem_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte 0 is the most significant lane of the word.
    always_comb begin
        case (offset)
            2'd0:    w_byte = mem_word[31:24];
            2'd1:    w_byte = mem_word[23:16];
            2'd2:    w_byte = mem_word[15:8];
            default: w_byte = mem_word[7:0];
        endcase
        w_half = offset[1] ? mem_word[15:0] : mem_word[31:16];
    end

    always_comb begin
        case (op)
            OP_LB:   load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  load_data = {24'd0, w_byte};
            OP_LH:   load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  load_data = {16'd0, w_half};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        case (op)
            OP_SB: begin
                case (offset)
                    2'd0:    merged_word[31:24] = store_data[7:0];
                    2'd1:    merged_word[23:16] = store_data[7:0];
                    2'd2:    merged_word[15:8]  = store_data[7:0];
                    default: merged_word[7:0]   = store_data[7:0];
                endcase
            end
            OP_SH: begin
                if (offset[1]) merged_word[15:0]  = store_data[15:0];
                else           merged_word[31:16] = store_data[15:0];
            end
            default: merged_word = store_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : MIPS-style byte/half/word load-store sequencer for a
//                   fixed-latency big-endian word memory (RMW for sub-word stores)
// Rev 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int SIZE_WARD = 2,
    parameter int AW        = $clog2(4 * SIZE_WARD),
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_data,
    output logic          resp_err,
    output logic [AW-1:0] address,
    output logic [31:0]   write_data,
    output logic          memread,
    output logic          memwrite,
    input  logic [31:0]   read_data
);

    lsu_state_e           r_state;
    mem_op_e              r_op;
    logic [1:0]           r_off;
    logic [31:0]          r_wdata;
    logic [LAT_CNT_W-1:0] r_lat_cnt;

    mem_op_e     w_req_op;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_req_op = mem_op_e'(req_op);

    lane_merge u_lane_merge (
        .op          (r_op),
        .offset      (r_off),
        .mem_word    (read_data),
        .store_data  (r_wdata),
        .load_data   (w_load_data),
        .merged_word (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_LB;
            r_off      <= 2'd0;
            r_wdata    <= 32'd0;
            r_lat_cnt  <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_err   <= 1'b0;
            address    <= '0;
            write_data <= 32'd0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        r_op      <= w_req_op;
                        r_off     <= req_addr[1:0];
                        r_wdata   <= req_wdata;
                        address   <= {req_addr[AW-1:2], 2'b00};
                        req_ready <= 1'b0;
                        if (is_misaligned(w_req_op, req_addr[1:0])) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'd0;
                            r_state    <= ST_RESP;
                        end else if (w_req_op == OP_SW) begin
                            write_data <= req_wdata;
                            memwrite   <= 1'b1;
                            r_state    <= ST_WR;
                        end else begin
                            // Loads and sub-word stores both start with a word read.
                            memread   <= 1'b1;
                            r_lat_cnt <= LAT_CNT_W'(RD_LAT - 1);
                            r_state   <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        memread <= 1'b0;
                        if (r_op == OP_SB || r_op == OP_SH) begin
                            write_data <= w_merged;
                            memwrite   <= 1'b1;
                            r_state    <= ST_WR;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_data  <= w_load_data;
                            r_state    <= ST_RESP;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                ST_WR: begin
                    memwrite   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= 32'd0;
                    r_state    <= ST_RESP;
                end
                default: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_data  <= 32'd0;
                        req_ready  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int SIZE_WARD = 2;
    localparam int AW        = 3;
    localparam int LAT       = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'd0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic [AW-1:0] address;
    logic [31:0]   write_data;
    logic          memread;
    logic          memwrite;
    logic [31:0]   read_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.SIZE_WARD(SIZE_WARD), .AW(AW), .RD_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .address    (address),
        .write_data (write_data),
        .memread    (memread),
        .memwrite   (memwrite),
        .read_data  (read_data)
    );

    // Word memory plus strobe monitors
    logic [31:0] mem [SIZE_WARD];
    logic        init_en = 1'b0;
    logic        init_idx = 1'b0;
    logic [31:0] init_val = 32'd0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          ovl_cnt = 0;
    logic [31:0] last_wr = 32'd0;

    assign read_data = mem[address[2]];

    always @(posedge clk) begin
        if (init_en)       mem[init_idx] <= init_val;
        else if (memwrite) mem[address[2]] <= write_data;
        if (memread)             rd_cnt  <= rd_cnt + 1;
        if (memwrite)            wr_cnt  <= wr_cnt + 1;
        if (memread && memwrite) ovl_cnt <= ovl_cnt + 1;
        if (memwrite)            last_wr <= write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr, input logic [31:0] wd);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int guard = 0;
        while (!resp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!resp_valid) check("resp_valid_timeout", {31'd0, resp_valid}, 32'd1);
    endtask

    task automatic xact(input logic [2:0] op, input logic [AW-1:0] addr, input logic [31:0] wd,
                        output logic [31:0] data, output logic err);
        issue(op, addr, wd);
        wait_resp();
        data = resp_data;
        err  = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [2:0] op, input logic [AW-1:0] addr,
                              input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        int          rd0 = rd_cnt;
        int          wr0 = wr_cnt;
        xact(op, addr, 32'd0, d, e);
        check({tag, "_data"}, d, exp);
        check({tag, "_err"}, {31'd0, e}, 32'd0);
        check({tag, "_rd_cycles"}, 32'(rd_cnt - rd0), 32'(LAT));
        check({tag, "_wr_cycles"}, 32'(wr_cnt - wr0), 32'd0);
    endtask

    task automatic store_check(input string tag, input logic [2:0] op, input logic [AW-1:0] addr,
                               input logic [31:0] wd, input logic [31:0] exp_word, input int exp_rd);
        logic [31:0] d;
        logic        e;
        int          rd0 = rd_cnt;
        int          wr0 = wr_cnt;
        xact(op, addr, wd, d, e);
        check({tag, "_data"}, d, 32'd0);
        check({tag, "_err"}, {31'd0, e}, 32'd0);
        check({tag, "_rd_cycles"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, "_wr_cycles"}, 32'(wr_cnt - wr0), 32'd1);
        check({tag, "_write_data"}, last_wr, exp_word);
        check({tag, "_mem"}, mem[addr[2]], exp_word);
        check({tag, "_overlap"}, 32'(ovl_cnt), 32'd0);
    endtask

    task automatic err_check(input string tag, input logic [2:0] op, input logic [AW-1:0] addr);
        logic [31:0] d;
        logic        e;
        int          rd0 = rd_cnt;
        int          wr0 = wr_cnt;
        xact(op, addr, 32'hFFFF_FFFF, d, e);
        check({tag, "_data"}, d, 32'd0);
        check({tag, "_err"}, {31'd0, e}, 32'd1);
        check({tag, "_strobes"}, 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    endtask

    initial begin
        int guard;
        int wr0;

        // Reset state
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_strobes", {30'd0, memread, memwrite}, 32'd0);
        check("rst_address", {29'd0, address}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        @(negedge clk);
        init_en = 1'b1; init_idx = 1'b0; init_val = 32'h8012_34FF;
        @(negedge clk);
        init_idx = 1'b1; init_val = 32'h1122_3344;
        @(negedge clk);
        init_en = 1'b0;

        // Loads with extension, both words
        load_check("lb0",  3'd0, 3'd0, 32'hFFFF_FF80);
        check("back_to_back_ready", {31'd0, req_ready}, 32'd1);
        load_check("lbu3", 3'd1, 3'd3, 32'h0000_00FF);
        load_check("lh2",  3'd2, 3'd2, 32'h0000_34FF);
        load_check("lhu0", 3'd3, 3'd0, 32'h0000_8012);
        load_check("lh0",  3'd2, 3'd0, 32'hFFFF_8012);
        load_check("lw4",  3'd4, 3'd4, 32'h1122_3344);
        load_check("lb5",  3'd0, 3'd5, 32'h0000_0022);
        load_check("lb7",  3'd0, 3'd7, 32'h0000_0044);

        // Stores: RMW for sub-word, direct write for word
        store_check("sb1", 3'd5, 3'd1, 32'h0000_00AB, 32'h80AB_34FF, LAT);
        store_check("sh6", 3'd6, 3'd6, 32'h1234_BEEF, 32'h1122_BEEF, LAT);
        load_check("lh6_after_sh", 3'd2, 3'd6, 32'hFFFF_BEEF);
        store_check("sw4", 3'd7, 3'd4, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
        load_check("lbu4_after_sw", 3'd1, 3'd4, 32'h0000_00CA);

        // Misaligned accesses
        err_check("lw2_misaligned", 3'd4, 3'd2);
        err_check("sh3_misaligned", 3'd6, 3'd3);
        err_check("lh1_misaligned", 3'd2, 3'd1);
        check("misaligned_mem0_intact", mem[0], 32'h80AB_34FF);

        // Response back-pressure; new requests ignored while busy
        wr0 = wr_cnt;
        issue(3'd4, 3'd0, 32'd0);
        wait_resp();
        for (int i = 0; i < 4; i++) begin
            check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_resp_data", resp_data, 32'h80AB_34FF);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            if (i < 3) begin
                req_valid = 1'b1; req_op = 3'd7; req_addr = 3'd0; req_wdata = 32'h0;
            end else begin
                req_valid = 1'b0;
                resp_ready = 1'b1;
            end
            @(negedge clk);
        end
        resp_ready = 1'b0;
        check("hold_exit_valid", {31'd0, resp_valid}, 32'd0);
        check("ignored_req_no_write", 32'(wr_cnt - wr0), 32'd0);

        // Reset asserted in the write phase of an SH
        issue(3'd6, 3'd0, 32'h0000_5555);
        guard = 0;
        while (!memwrite && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("sh_reached_wr", {31'd0, memwrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_memwrite_async", {31'd0, memwrite}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd0);
        check("abort_address", {29'd0, address}, 32'd0);
        check("abort_write_data", write_data, 32'd0);
        @(negedge clk);
        check("abort_mem_unchanged", mem[0], 32'h80AB_34FF);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_next_edge", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        load_check("lw0_after_abort", 3'd4, 3'd0, 32'h80AB_34FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
